// File: rtl/gigatron_pkg.sv
// Shared types and constants for the Gigatron GT1 loader.
package gigatron_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEG_HI,
        ST_SEG_LO,
        ST_SEG_LEN,
        ST_DATA,
        ST_START_HI,
        ST_START_LO,
        ST_DONE,
        ST_ERR
    } gt1_state_t;

    localparam logic [7:0] GT1_TERMINATOR = 8'h00;
    localparam logic [7:0] GT1_LEN_256    = 8'h00;

    localparam int GIGATRON_RAM_AW_32K    = 15;
    localparam int GIGATRON_RAM_AW_64K    = 16;
    localparam int GIGATRON_RAM_BYTES_32K = 32768;
    localparam int GIGATRON_RAM_BYTES_64K = 65536;

endpackage

// File: rtl/gt1_grant_timer.sv
// Bus-grant watchdog: counts cycles from start until GNT_TIMEOUT, then holds expired.
module gt1_grant_timer #(
    parameter int GNT_TIMEOUT = 1023
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(GNT_TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          run;

    assign expired = run && (cnt == CW'(GNT_TIMEOUT));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            run <= 1'b1;
        end else if (clear) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gt1_loader_ctrl.sv
// GT1 image loader: parses the HPS download stream into segments and writes
// them into Gigatron RAM while holding the CPU off the bus.
module gt1_loader_ctrl
    import gigatron_pkg::*;
#(
    parameter int RAM_AW      = 15,
    parameter int GNT_TIMEOUT = 1023
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic [15:0]       start_addr,
    output logic              load_done,
    output logic              load_error,
    output logic              busy
);

    gt1_state_t  state, state_d;
    logic        dl_q;
    logic        dl_rise;
    logic        first_seg;
    logic [7:0]  seg_hi, seg_lo, start_hi;
    logic [8:0]  count;
    logic [15:0] addr16;
    logic        granted;
    logic        take;
    logic        tmr_start, tmr_clear, tmr_expired;

    assign dl_rise = ioctl_download && !dl_q;
    assign granted = (state == ST_SEG_HI)   || (state == ST_SEG_LO)  ||
                     (state == ST_SEG_LEN)  || (state == ST_DATA)    ||
                     (state == ST_START_HI) || (state == ST_START_LO);
    // A byte only counts while the CPU is still halted.
    assign take    = granted && ioctl_wr && bus_gnt;
    assign addr16  = {seg_hi, seg_lo};

    assign ioctl_wait = (state == ST_REQ);
    assign bus_req    = (state == ST_REQ) || granted;
    assign busy       = bus_req;
    assign load_done  = (state == ST_DONE);

    assign tmr_start = (state == ST_IDLE) && dl_rise;
    assign tmr_clear = (state == ST_REQ) && (state_d != ST_REQ);

    gt1_grant_timer #(.GNT_TIMEOUT(GNT_TIMEOUT)) u_gnt_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .start   (tmr_start),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (dl_rise) state_d = ST_REQ;
            ST_REQ: begin
                if (!ioctl_download)  state_d = ST_ERR;
                else if (bus_gnt)     state_d = ST_SEG_HI;
                else if (tmr_expired) state_d = ST_ERR;
            end
            ST_SEG_HI, ST_SEG_LO, ST_SEG_LEN, ST_DATA, ST_START_HI, ST_START_LO: begin
                if (!bus_gnt) begin
                    state_d = ST_ERR;
                end else begin
                    if (ioctl_wr) begin
                        case (state)
                            ST_SEG_HI:   state_d = (ioctl_dout == GT1_TERMINATOR && !first_seg)
                                                   ? ST_START_HI : ST_SEG_LO;
                            ST_SEG_LO:   state_d = ST_SEG_LEN;
                            ST_SEG_LEN:  state_d = ST_DATA;
                            ST_DATA:     if (count == 9'd1) state_d = ST_SEG_HI;
                            ST_START_HI: state_d = ST_START_LO;
                            ST_START_LO: state_d = ST_DONE;
                            default:     state_d = state;
                        endcase
                    end
                    // The byte arriving with the download's end is honoured first.
                    if (!ioctl_download && state_d != ST_DONE) state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  if (!ioctl_download) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q       <= 1'b0;
            first_seg  <= 1'b0;
            seg_hi     <= '0;
            seg_lo     <= '0;
            start_hi   <= '0;
            count      <= '0;
            start_addr <= '0;
            load_error <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
        end else begin
            dl_q   <= ioctl_download;
            ram_we <= 1'b0;

            if (state == ST_IDLE && dl_rise)
                load_error <= 1'b0;
            if (state_d == ST_ERR && state != ST_ERR)
                load_error <= 1'b1;
            // HPS must not strobe while stalled; the byte is lost, so flag it.
            if (state == ST_REQ && ioctl_wr)
                load_error <= 1'b1;

            if (state == ST_REQ && state_d == ST_SEG_HI)
                first_seg <= 1'b1;

            if (take) begin
                case (state)
                    ST_SEG_HI:  seg_hi <= ioctl_dout;
                    ST_SEG_LO:  seg_lo <= ioctl_dout;
                    ST_SEG_LEN: begin
                        count     <= (ioctl_dout == GT1_LEN_256) ? 9'd256 : {1'b0, ioctl_dout};
                        first_seg <= 1'b0;
                    end
                    ST_DATA: begin
                        ram_we   <= 1'b1;
                        ram_addr <= addr16[RAM_AW-1:0];
                        ram_data <= ioctl_dout;
                        seg_lo   <= seg_lo + 8'd1;
                        count    <= count - 9'd1;
                    end
                    ST_START_HI: start_hi   <= ioctl_dout;
                    ST_START_LO: start_addr <= {start_hi, ioctl_dout};
                    default: ;
                endcase
            end
        end
    end

endmodule
